lane_route_sched: RTL and testbench

//  Scheduler/configurator for a LANES-wide tuple-lane router. Each lane carries a 1-bit flag field and a

---
 rtl/lane_route_sched.sv | 140 ++++++++++++++
 tb/tb_lane_route_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_route_sched.sv
// Lane router scheduler: routes per-lane flag and data fields through active
// selector tables into a single output register on a valid/ready stream.
// New tables are captured into a shadow copy and only become active at a frame
// boundary once the output register has drained, counted by epoch.
module lane_route_sched #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 2,
  parameter int SEL_W   = 2,
  parameter int EPOCH_W = 4
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESET,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_flag,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_flag,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [LANES*SEL_W-1:0]    cfg_flag_sel,
  input  logic [LANES*SEL_W-1:0]    cfg_data_sel,
  output logic                      busy,
  output logic [EPOCH_W-1:0]        epoch
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_APPLY = 2'd3;

  // Reset flag table reverses lane order; reset data table is identity.
  function automatic logic [LANES*SEL_W-1:0] reversal_table();
    logic [LANES*SEL_W-1:0] t;
    t = '0;
    for (int i = 0; i < LANES; i++) t[i*SEL_W +: SEL_W] = SEL_W'(LANES - 1 - i);
    return t;
  endfunction

  function automatic logic [LANES*SEL_W-1:0] identity_table();
    logic [LANES*SEL_W-1:0] t;
    t = '0;
    for (int i = 0; i < LANES; i++) t[i*SEL_W +: SEL_W] = SEL_W'(i);
    return t;
  endfunction

  localparam logic [LANES*SEL_W-1:0] DEF_FLAG_SEL = reversal_table();
  localparam logic [LANES*SEL_W-1:0] DEF_DATA_SEL = identity_table();

  logic [1:0]               state;
  logic                     frame_open;
  logic                     load;
  logic [LANES*SEL_W-1:0]   act_flag_sel;
  logic [LANES*SEL_W-1:0]   act_data_sel;
  logic [LANES*SEL_W-1:0]   shd_flag_sel;
  logic [LANES*SEL_W-1:0]   shd_data_sel;
  logic [LANES-1:0]         routed_flag;
  logic [LANES*DATA_W-1:0]  routed_data;

  // A pending config holds off the first beat of the next frame but never splits an open one.
  assign in_ready  = (!out_valid || out_ready) && !((state != ST_RUN) && !frame_open);
  assign load      = in_valid && in_ready;
  assign cfg_ready = (state == ST_RUN);
  assign busy      = (state != ST_RUN);

  // Crossbar: every output lane picks its flag and data source independently.
  always_comb begin
    routed_flag = '0;
    routed_data = '0;
    for (int i = 0; i < LANES; i++) begin
      routed_flag[i] = in_flag[act_flag_sel[i*SEL_W +: SEL_W]];
      routed_data[i*DATA_W +: DATA_W] = in_data[act_data_sel[i*SEL_W +: SEL_W]*DATA_W +: DATA_W];
    end
  end

  // Output register: load on accept, clear only when drained with nothing new behind it.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      out_valid <= 1'b0;
      out_flag  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_flag  <= routed_flag;
      out_data  <= routed_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Track whether the stream is in the middle of a frame.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      frame_open <= 1'b0;
    end else if (load) begin
      frame_open <= !in_last;
    end
  end

  // Config sequencer: capture to shadow, wait for frame close and empty output, then swap tables.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state        <= ST_RUN;
      epoch        <= '0;
      act_flag_sel <= DEF_FLAG_SEL;
      act_data_sel <= DEF_DATA_SEL;
      shd_flag_sel <= DEF_FLAG_SEL;
      shd_data_sel <= DEF_DATA_SEL;
    end else begin
      case (state)
        ST_RUN: begin
          if (cfg_valid) begin
            shd_flag_sel <= cfg_flag_sel;
            shd_data_sel <= cfg_data_sel;
            state        <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (!frame_open) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!out_valid || out_ready) state <= ST_APPLY;
        end
        default: begin
          act_flag_sel <= shd_flag_sel;
          act_data_sel <= shd_data_sel;
          epoch        <= epoch + EPOCH_W'(1);
          state        <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_route_sched.sv
// Testbench for lane_route_sched: directed scenarios plus a randomized phase,
// checked by a scoreboard fed from a table-level reference model.
module tb_lane_route_sched;

  localparam int LANES   = 4;
  localparam int DATA_W  = 2;
  localparam int SEL_W   = 2;
  localparam int EPOCH_W = 4;

  logic                     CLK = 1'b0;
  logic                     ASYNCRESET;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES-1:0]         in_flag;
  logic [LANES*DATA_W-1:0]  in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES-1:0]         out_flag;
  logic [LANES*DATA_W-1:0]  out_data;
  logic                     out_last;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [LANES*SEL_W-1:0]   cfg_flag_sel;
  logic [LANES*SEL_W-1:0]   cfg_data_sel;
  logic                     busy;
  logic [EPOCH_W-1:0]       epoch;

  typedef struct packed {
    logic [LANES-1:0]        flag;
    logic [LANES*DATA_W-1:0] data;
    logic                    last;
  } beat_t;

  beat_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: active and pending tables as plain source indices.
  int m_flag_sel[LANES];
  int m_data_sel[LANES];
  int p_flag_sel[LANES];
  int p_data_sel[LANES];
  bit m_pending;
  bit m_frame_open;
  int m_applied;

  beat_t held;
  bit    hold_valid = 1'b0;

  lane_route_sched #(
    .LANES(LANES), .DATA_W(DATA_W), .SEL_W(SEL_W), .EPOCH_W(EPOCH_W)
  ) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_flag(in_flag),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_flag(out_flag),
    .out_data(out_data), .out_last(out_last),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_flag_sel(cfg_flag_sel), .cfg_data_sel(cfg_data_sel),
    .busy(busy), .epoch(epoch)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int field(input logic [31:0] bus, input int idx, input int w);
    return int'((bus >> (w * idx)) & ((32'd1 << w) - 32'd1));
  endfunction

  function automatic beat_t model_route(input logic [LANES-1:0] f, input logic [LANES*DATA_W-1:0] d,
                                        input logic l);
    beat_t b;
    logic [31:0] fl;
    logic [31:0] dt;
    fl = 0;
    dt = 0;
    for (int i = 0; i < LANES; i++) begin
      fl = fl | (32'(field(32'(f), m_flag_sel[i], 1)) << i);
      dt = dt | (32'(field(32'(d), m_data_sel[i], DATA_W)) << (DATA_W * i));
    end
    b.flag = fl[LANES-1:0];
    b.data = dt[LANES*DATA_W-1:0];
    b.last = l;
    return b;
  endfunction

  function automatic int exp_epoch();
    return (m_applied + ((m_pending && !m_frame_open) ? 1 : 0)) % (1 << EPOCH_W);
  endfunction

  // Reference model: predicts each accepted beat and tracks config application at frame boundaries.
  always @(negedge CLK) begin
    if (ASYNCRESET) begin
      for (int i = 0; i < LANES; i++) begin
        m_flag_sel[i] = LANES - 1 - i;
        m_data_sel[i] = i;
      end
      m_pending    = 1'b0;
      m_frame_open = 1'b0;
      m_applied    = 0;
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        if (m_pending && !m_frame_open) begin
          m_flag_sel = p_flag_sel;
          m_data_sel = p_data_sel;
          m_pending  = 1'b0;
          m_applied++;
        end
        exp_q.push_back(model_route(in_flag, in_data, in_last));
        m_frame_open = !in_last;
      end
      if (cfg_valid && cfg_ready) begin
        check_output("cfg_taken_mid_pending", 32'(m_pending && m_frame_open), 32'd0);
        if (m_pending && !m_frame_open) begin
          m_flag_sel = p_flag_sel;
          m_data_sel = p_data_sel;
          m_applied++;
        end
        for (int i = 0; i < LANES; i++) begin
          p_flag_sel[i] = field(32'(cfg_flag_sel), i, SEL_W);
          p_data_sel[i] = field(32'(cfg_data_sel), i, SEL_W);
        end
        m_pending = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each output transfer and checks stalled outputs stay put.
  always @(negedge CLK) begin
    if (ASYNCRESET) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check_output("hold_stable", 32'({out_valid, out_flag, out_data, out_last}),
                     32'({1'b1, held}));
      end
      if (out_valid && out_ready) begin
        hold_valid = 1'b0;
        if (exp_q.size() == 0) begin
          check_output("unexpected_beat", 32'({out_flag, out_data, out_last}), 32'hFFFF_FFFF);
        end else begin
          check_output("routed_beat", 32'({out_flag, out_data, out_last}), 32'(exp_q.pop_front()));
        end
      end else if (out_valid) begin
        held       = {out_flag, out_data, out_last};
        hold_valid = 1'b1;
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input logic [LANES-1:0] f, input logic [LANES*DATA_W-1:0] d,
                                input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_flag  = f;
    in_data  = d;
    in_last  = l;
    @(negedge CLK);
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) check_output("send_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic offer_cfg(input logic [LANES*SEL_W-1:0] fs, input logic [LANES*SEL_W-1:0] ds);
    int n;
    n            = 0;
    cfg_valid    = 1'b1;
    cfg_flag_sel = fs;
    cfg_data_sel = ds;
    @(negedge CLK);
    while (!cfg_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!cfg_ready) check_output("cfg_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    cfg_valid = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    ASYNCRESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [3:0] e0;
    in_valid     = 1'b0;
    in_flag      = '0;
    in_data      = '0;
    in_last      = 1'b0;
    out_ready    = 1'b1;
    cfg_valid    = 1'b0;
    cfg_flag_sel = '0;
    cfg_data_sel = '0;
    do_reset();

    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_out_flag", 32'(out_flag), 32'd0);
    check_output("reset_out_data", 32'(out_data), 32'd0);
    check_output("reset_out_last", 32'(out_last), 32'd0);
    check_output("reset_epoch", 32'(epoch), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);

    // Scenario 1: default tables reverse flags, pass data straight through.
    apply_stimulus(4'b0001, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1);
    check_output("s1_out_valid", 32'(out_valid), 32'd1);
    check_output("s1_out_flag", 32'(out_flag), 32'b1000);
    check_output("s1_out_data", 32'(out_data), 32'b11100100);
    check_output("s1_out_last", 32'(out_last), 32'd1);
    @(posedge CLK);
    #1;

    // Scenario 2: full-throughput stream, then backpressure.
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_flag  = 4'($urandom);
      in_data  = 8'($urandom);
      in_last  = (k == 7);
      @(negedge CLK);
      check_output("s2_in_ready", 32'(in_ready), 32'd1);
      @(posedge CLK);
      #1;
      check_output("s2_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b0;
    in_flag   = 4'($urandom);
    in_data   = 8'($urandom);
    in_last   = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check_output("s2_stall_in_ready", 32'(in_ready), 32'd0);
      check_output("s2_stall_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    @(negedge CLK);
    check_output("s2_resume_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Scenario 3: config arrives mid-frame; frame finishes on the old tables.
    apply_stimulus(4'($urandom), 8'($urandom), 1'b0);
    cfg_valid    = 1'b1;
    cfg_flag_sel = {2'd3, 2'd2, 2'd1, 2'd0};
    cfg_data_sel = {2'd0, 2'd1, 2'd2, 2'd3};
    @(posedge CLK);
    #1;
    cfg_valid = 1'b0;
    check_output("s3_busy", 32'(busy), 32'd1);
    apply_stimulus(4'($urandom), 8'($urandom), 1'b0);
    apply_stimulus(4'($urandom), 8'($urandom), 1'b0);
    apply_stimulus(4'($urandom), 8'($urandom), 1'b1);
    for (int n = 0; n < 20 && busy; n++) begin
      @(posedge CLK);
      #1;
    end
    check_output("s3_busy_cleared", 32'(busy), 32'd0);
    check_output("s3_epoch", 32'(epoch), 32'd1);
    apply_stimulus(4'b0001, 8'b11100100, 1'b1);
    check_output("s3_new_flag", 32'(out_flag), 32'b0001);
    check_output("s3_new_data", 32'(out_data), 32'b00011011);
    repeat (3) @(posedge CLK);
    #1;

    // Scenario 4: idle config walks through the sequencer in four cycles.
    e0           = epoch;
    cfg_valid    = 1'b1;
    cfg_flag_sel = 8'($urandom);
    cfg_data_sel = 8'($urandom);
    @(negedge CLK);
    check_output("s4_cfg_ready", 32'(cfg_ready), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK);
      #1;
      cfg_flag_sel = 8'($urandom);
      cfg_data_sel = 8'($urandom);
      check_output("s4_busy", 32'(busy), 32'd1);
      check_output("s4_cfg_blocked", 32'(cfg_ready), 32'd0);
    end
    @(posedge CLK);
    #1;
    cfg_valid = 1'b0;
    check_output("s4_back_to_run", 32'(busy), 32'd0);
    check_output("s4_epoch", 32'(epoch), 32'(e0 + 4'd1));
    check_output("s4_epoch_model", 32'(epoch), 32'(exp_epoch()));
    repeat (3) @(posedge CLK);
    #1;

    // Scenario 5: broadcast data selector, then enough configs to wrap epoch.
    offer_cfg(8'($urandom), {2'd2, 2'd2, 2'd2, 2'd2});
    apply_stimulus(4'($urandom), {2'd0, 2'd1, 2'd3, 2'd2}, 1'b1);
    check_output("s5_broadcast", 32'(out_data), 32'b01010101);
    @(posedge CLK);
    #1;
    e0 = epoch;
    for (int k = 0; k < 16; k++) offer_cfg(8'($urandom), 8'($urandom));
    check_output("s5_epoch_wrap", 32'(epoch), 32'(e0));
    check_output("s5_epoch_model", 32'(epoch), 32'(exp_epoch()));

    // Randomized traffic with occasional reconfiguration and backpressure.
    for (int k = 0; k < 600; k++) begin
      in_valid     = ($urandom % 4) != 0;
      in_flag      = 4'($urandom);
      in_data      = 8'($urandom);
      in_last      = ($urandom % 4) == 0;
      out_ready    = ($urandom % 3) != 0;
      cfg_valid    = ($urandom % 12) == 0;
      cfg_flag_sel = 8'($urandom);
      cfg_data_sel = 8'($urandom);
      @(posedge CLK);
      #1;
    end
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    if (m_frame_open) apply_stimulus(4'($urandom), 8'($urandom), 1'b1);
    repeat (10) @(posedge CLK);
    #1;
    check_output("rand_epoch", 32'(epoch), 32'(exp_epoch()));
    check_output("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Scenario 6: reset while a config is pending and a beat is held.
    out_ready = 1'b0;
    apply_stimulus(4'($urandom), 8'($urandom), 1'b0);
    cfg_valid    = 1'b1;
    cfg_flag_sel = {2'd0, 2'd1, 2'd2, 2'd3};
    cfg_data_sel = {2'd1, 2'd1, 2'd1, 2'd1};
    @(posedge CLK);
    #1;
    cfg_valid = 1'b0;
    check_output("s6_busy", 32'(busy), 32'd1);
    check_output("s6_held_valid", 32'(out_valid), 32'd1);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    check_output("s6_async_out_valid", 32'(out_valid), 32'd0);
    check_output("s6_async_busy", 32'(busy), 32'd0);
    check_output("s6_async_epoch", 32'(epoch), 32'd0);
    @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
    out_ready  = 1'b1;
    apply_stimulus(4'b0001, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1);
    check_output("s6_default_flag", 32'(out_flag), 32'b1000);
    check_output("s6_default_data", 32'(out_data), 32'b11100100);
    check_output("s6_epoch", 32'(epoch), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
